segment_capture: RTL and testbench
==================================

Name: segment_capture

Overview:
- Read-back receiver for the multiplexed 7-segment display interface; it is the reading end of the display driver's digit-select/segment bus.
- Samples the one-hot digit select and the segment lines, and decodes each segment pattern to a BCD digit.
- Assembles complete scan frames into the 12-bit time word {hours[5:0], minutes[5:0]}.
- Used for on-chip self-check and board bring-up: its output is compared against the time value that was sent to the display.

Parameters:
- SETTLE_CYCLES, 2: cycles bytee must stay unchanged and one-hot before segment is sampled (range 1..15).
- FRAMES_STABLE, 2: consecutive identical legal frames required before data_out updates (range 1..7).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bytee  input  4  digit select, one-hot: 0001 = minute ones, 0010 = minute tens, 0100 = hour ones, 1000 = hour tens; 0000 = blank slot
- segment  input  7  segment lines, active-high, bit0 = a … bit6 = g
- data_out  output  12  last stable decoded value, {hours[11:6], minutes[5:0]}, binary
- data_valid  output  1  one-cycle pulse when data_out is loaded
- locked  output  1  level; high once data_out has been loaded at least once since reset
- seg_error  output  1  one-cycle pulse on an illegal segment pattern at sample time
- sel_error  output  1  one-cycle pulse when bytee is non-zero and not one-hot

Behaviour:
- Reset: synchronous, active-high, applied on the clock edge. All outputs, digit registers, seen/bad flags, settle counter, match counter and candidate register go to 0. Reset asserted mid-frame discards the partial frame.
- Settle counter:
  - Tracks the previous bytee value.
  - Clears when bytee changes, when bytee == 0, or when bytee is not one-hot.
  - Otherwise increments and saturates.
  - Sample strobe fires exactly once per slot: on the cycle the counter reaches SETTLE_CYCLES-1, i.e. the SETTLE_CYCLES-th cycle of an unchanged one-hot bytee.
  - A slot shorter than SETTLE_CYCLES is ignored (no capture, no error).
- sel_error:
  - Pulses the cycle after the non-one-hot value first appears.
  - Does not pulse again while that same value persists.
  - Clears the seen flags, aborting the current frame.
- Decode at sample strobe. Legal patterns (hex, g..a):
  - 3F → 0, 06 → 1, 5B → 2, 4F → 3, 66 → 4
  - 6D → 5, 7D → 6, 07 → 7, 7F → 8, 6F → 9
  - Any other pattern: seg_error pulses the next cycle and the slot's bad flag is set.
  - In either case the 4-bit digit register for the selected slot is written (0 if illegal) and its seen flag is set.
- Frame completion:
  - Evaluated the cycle after the strobe that sets the fourth seen flag.
  - minutes = mt*10 + mo; hours = ht*10 + ho (each 6 bits, computed without truncation before the range check).
  - Frame is legal iff no bad flag is set, mt ≤ 5, and hours ≤ 23.
  - All seen and bad flags clear after evaluation.
  - A slot re-sampled before the frame completes overwrites its digit; this does not error.
- Stability filter:
  - Legal frame equal to the candidate: match counter increments (saturating).
  - Legal frame different from the candidate: candidate is loaded and match = 1.
  - Illegal frame: match = 0; candidate is unchanged.
  - When match reaches FRAMES_STABLE and (candidate != data_out or locked == 0): data_out is loaded on the same edge, data_valid pulses for one cycle and locked is set.
  - An unchanged stable value produces no further data_valid pulses.
- Latency: from the sample strobe of the final digit of the qualifying frame, data_out and data_valid are visible 2 cycles later.
- Simultaneous events: a sel_error abort and a frame-complete evaluation in the same cycle resolve as abort; no evaluation occurs. seg_error and data_valid never coincide for the same frame.

Test Plan:
- Scan digits 2,3,4,5 (ht,ho,mt,mo = 5B,4F,66,6D), 4 cycles per slot, 2 frames → data_out = {6'd23, 6'd45} = 12'h5ED, single data_valid pulse, locked = 1; a third identical frame produces no pulse.
- Same scan, but the mt slot is held for only 1 cycle (SETTLE_CYCLES = 2) → that slot is ignored, the frame does not complete until mt is re-shown, and there are no errors.
- segment = 7'h00 in the mo slot → seg_error pulses, match resets, data_out is unchanged; following legal frames 12:34 ×2 → data_out = 12'h322.
- Hours 24 (ht = 2, ho = 4) with legal segments → no error pulse and no update; mt = 6 is likewise rejected.
- bytee = 0011 mid-frame → one sel_error pulse, partial frame discarded; the next two complete frames 00:00 → data_out = 0, data_valid pulses (first lock).
- reset asserted for 1 cycle between the two frames of a 2-frame sequence → all outputs 0 after the edge; two further frames are required before data_valid.

Source files
------------

// File: rtl/segment_capture.sv
// Read-back receiver for the multiplexed 7-segment bus: samples each settled digit
// slot, decodes it to BCD, and publishes {hours, minutes} once frames are stable.
module segment_capture #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FRAMES_STABLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  bytee,
    input  logic [6:0]  segment,
    output logic [11:0] data_out,
    output logic        data_valid,
    output logic        locked,
    output logic        seg_error,
    output logic        sel_error
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] STABLE_N    = 3'(FRAMES_STABLE);

    logic [3:0]       prev_bytee;
    logic [3:0]       settle_cnt;
    logic [3:0][3:0]  digit;
    logic [3:0]       seen;
    logic [3:0]       bad;
    logic [11:0]      cand;
    logic [2:0]       match;

    logic             one_hot;
    logic [3:0]       cnt_cur;
    logic             strobe;
    logic             abort;
    logic             eval;
    logic [3:0]       dec;
    logic             dec_ok;
    logic [6:0]       minutes;
    logic [6:0]       hours;
    logic             frame_ok;
    logic [11:0]      frame_val;
    logic [11:0]      cand_nxt;
    logic [2:0]       match_nxt;
    logic             load;

    always_comb begin
        one_hot = (bytee != 4'd0) && ((bytee & (bytee - 4'd1)) == 4'd0);
        // cnt_cur is the zero-based age of the current slot; the register holds it for next cycle
        if (bytee != prev_bytee || !one_hot)
            cnt_cur = 4'd0;
        else if (settle_cnt == 4'hF)
            cnt_cur = 4'hF;
        else
            cnt_cur = settle_cnt + 4'd1;
        strobe = one_hot && (cnt_cur == SETTLE_LAST);
        abort  = (bytee != 4'd0) && !one_hot && (bytee != prev_bytee);
        eval   = (&seen) && !abort;
    end

    always_comb begin
        dec    = 4'd0;
        dec_ok = 1'b1;
        case (segment)
            7'h3F: dec = 4'd0;
            7'h06: dec = 4'd1;
            7'h5B: dec = 4'd2;
            7'h4F: dec = 4'd3;
            7'h66: dec = 4'd4;
            7'h6D: dec = 4'd5;
            7'h7D: dec = 4'd6;
            7'h07: dec = 4'd7;
            7'h7F: dec = 4'd8;
            7'h6F: dec = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        minutes   = 7'(digit[1]) * 7'd10 + 7'(digit[0]);
        hours     = 7'(digit[3]) * 7'd10 + 7'(digit[2]);
        frame_ok  = (bad == 4'd0) && (digit[1] <= 4'd5) && (hours <= 7'd23);
        frame_val = {hours[5:0], minutes[5:0]};
        cand_nxt  = cand;
        match_nxt = match;
        if (eval) begin
            if (!frame_ok)
                match_nxt = 3'd0;
            else if (frame_val == cand)
                match_nxt = (match == 3'd7) ? 3'd7 : match + 3'd1;
            else begin
                cand_nxt  = frame_val;
                match_nxt = 3'd1;
            end
        end
        load = eval && frame_ok && (match_nxt >= STABLE_N) &&
               ((cand_nxt != data_out) || !locked);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_bytee <= 4'd0;
            settle_cnt <= 4'd0;
            digit      <= '0;
            seen       <= 4'd0;
            bad        <= 4'd0;
            cand       <= 12'd0;
            match      <= 3'd0;
            data_out   <= 12'd0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            seg_error  <= 1'b0;
            sel_error  <= 1'b0;
        end else begin
            prev_bytee <= bytee;
            settle_cnt <= cnt_cur;
            seg_error  <= strobe && !dec_ok;
            sel_error  <= abort;
            data_valid <= load;
            cand       <= cand_nxt;
            match      <= match_nxt;
            if (load) begin
                data_out <= cand_nxt;
                locked   <= 1'b1;
            end
            if (abort || eval) begin
                seen <= 4'd0;
                bad  <= 4'd0;
            end
            // a strobe landing on the evaluation cycle starts the next frame
            for (int i = 0; i < 4; i++) begin
                if (strobe && bytee[i]) begin
                    digit[i] <= dec_ok ? dec : 4'd0;
                    seen[i]  <= 1'b1;
                    bad[i]   <= !dec_ok;
                end
            end
        end
    end
endmodule

// File: tb/tb_segment_capture.sv
// Scoreboard bench for segment_capture: a digit/frame level model predicts every
// data_valid, seg_error and sel_error pulse; a monitor matches them as they appear.
module tb_segment_capture;
    localparam int SETTLE = 2;
    localparam int FS     = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  bytee = 4'd0;
    logic [6:0]  segment = 7'd0;
    logic [11:0] data_out;
    logic        data_valid, locked, seg_error, sel_error;

    segment_capture #(.SETTLE_CYCLES(SETTLE), .FRAMES_STABLE(FS)) dut (
        .clock(clock), .reset(reset), .bytee(bytee), .segment(segment),
        .data_out(data_out), .data_valid(data_valid), .locked(locked),
        .seg_error(seg_error), .sel_error(sel_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        logic [11:0] val;
    } dv_t;
    dv_t q_dv[$];
    int  q_seg[$];
    int  q_sel[$];

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0] bad_sel [8] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hC, 4'hF};

    // reference model state: digits per slot (0=mo,1=mt,2=ho,3=ht)
    int          m_dig [4];
    logic [3:0]  m_seen, m_bad, m_prev;
    int          m_run, m_match;
    bit          m_pend, m_lock;
    logic [11:0] m_cand, m_dout;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_seen = 0; m_bad = 0; m_prev = 0; m_run = 0; m_match = 0;
        m_pend = 0; m_lock = 0; m_cand = 0; m_dout = 0;
    endtask

    task automatic evaluate();
        int hr, mi;
        logic [11:0] v;
        hr = m_dig[3] * 10 + m_dig[2];
        mi = m_dig[1] * 10 + m_dig[0];
        if (m_bad == 0 && m_dig[1] <= 5 && hr <= 23) begin
            v = 12'(hr * 64 + mi);
            if (v == m_cand) m_match = (m_match < 7) ? m_match + 1 : 7;
            else begin m_cand = v; m_match = 1; end
            if (m_match >= FS && (m_cand != m_dout || !m_lock)) begin
                q_dv.push_back('{at: cyc, val: m_cand});
                m_dout = m_cand;
                m_lock = 1;
            end
        end else m_match = 0;
        m_seen = 0;
        m_bad  = 0;
    endtask

    task automatic sample(input logic [3:0] b, input logic [6:0] s);
        int slot = 0;
        int d = -1;
        for (int i = 0; i < 4; i++) if (b[i]) slot = i;
        for (int k = 0; k < 10; k++) if (pat[k] == s) d = k;
        if (d < 0) q_seg.push_back(cyc);
        m_dig[slot]  = (d < 0) ? 0 : d;
        m_bad[slot]  = (d < 0);
        m_seen[slot] = 1'b1;
        if (m_seen == 4'hF) m_pend = 1;
    endtask

    // called once per clock with the values the DUT sampled on edge 'cyc'
    task automatic step(input logic [3:0] b, input logic [6:0] s);
        bit oh, ab;
        oh = ($countones(b) == 1);
        ab = (b != 0) && !oh && (b != m_prev);
        if (ab) q_sel.push_back(cyc);
        if (m_pend) begin
            m_pend = 0;
            if (!ab) evaluate();
        end
        if (ab) begin m_seen = 0; m_bad = 0; end
        m_run = (b == m_prev) ? ((m_run < 100) ? m_run + 1 : m_run) : 1;
        if (oh && m_run == SETTLE) sample(b, s);
        m_prev = b;
    endtask

    task automatic show(input logic [3:0] b, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            bytee = b;
            segment = s;
            @(posedge clock);
            #1;
            step(b, s);
        end
    endtask

    task automatic frame_seg(input logic [6:0] s3, s2, s1, s0, input int len);
        show(4'b1000, s3, len);
        show(4'b0100, s2, len);
        show(4'b0010, s1, len);
        show(4'b0001, s0, len);
        show(4'b0000, 7'h00, 2);
    endtask

    task automatic frame(input int ht, ho, mt, mo, input int len);
        frame_seg(pat[ht], pat[ho], pat[mt], pat[mo], len);
    endtask

    task automatic do_reset();
        bytee = 0;
        segment = 0;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        model_reset();
        check("rst_data_out", data_out, 0);
        check("rst_locked", locked, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_errors", {seg_error, sel_error}, 0);
    endtask

    task automatic check_state(input string name);
        check({name, "_data_out"}, data_out, m_dout);
        check({name, "_locked"}, locked, m_lock);
    endtask

    dv_t mon_e;
    always @(negedge clock) begin
        if (data_valid) begin
            checks++;
            if (q_dv.size() == 0) begin
                errors++;
                $display("FAIL data_valid_unexpected: data_out=%h at cycle %0d, none expected", data_out, cyc);
            end else begin
                mon_e = q_dv.pop_front();
                if (mon_e.at != cyc || mon_e.val != data_out) begin
                    errors++;
                    $display("FAIL data_valid: got %h at cycle %0d, expected %h at cycle %0d",
                             data_out, cyc, mon_e.val, mon_e.at);
                end
            end
        end else if (q_dv.size() > 0 && q_dv[0].at <= cyc) begin
            checks++; errors++;
            mon_e = q_dv.pop_front();
            $display("FAIL data_valid_missing: got none, expected %h at cycle %0d", mon_e.val, mon_e.at);
        end
        if (seg_error) begin
            checks++;
            if (q_seg.size() == 0 || q_seg[0] != cyc) begin
                errors++;
                $display("FAIL seg_error: pulse at cycle %0d, expected cycle %0d", cyc,
                         (q_seg.size() == 0) ? -1 : q_seg[0]);
            end
            if (q_seg.size() > 0 && q_seg[0] <= cyc) void'(q_seg.pop_front());
        end else if (q_seg.size() > 0 && q_seg[0] <= cyc) begin
            checks++; errors++;
            $display("FAIL seg_error_missing: got 0, expected pulse at cycle %0d", q_seg.pop_front());
        end
        if (sel_error) begin
            checks++;
            if (q_sel.size() == 0 || q_sel[0] != cyc) begin
                errors++;
                $display("FAIL sel_error: pulse at cycle %0d, expected cycle %0d", cyc,
                         (q_sel.size() == 0) ? -1 : q_sel[0]);
            end
            if (q_sel.size() > 0 && q_sel[0] <= cyc) void'(q_sel.pop_front());
        end else if (q_sel.size() > 0 && q_sel[0] <= cyc) begin
            checks++; errors++;
            $display("FAIL sel_error_missing: got 0, expected pulse at cycle %0d", q_sel.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ht, ho, mt, mo, rep, len;
        logic [6:0] s [4];
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        do_reset();

        // 23:45 twice locks, a third copy is silent
        frame(2, 3, 4, 5, 4);
        frame(2, 3, 4, 5, 4);
        check("t1_value", data_out, 12'h5ED);
        check("t1_locked", locked, 1);
        frame(2, 3, 4, 5, 4);
        check_state("t1");

        // short mt slot is ignored until re-shown
        show(4'b1000, pat[2], 4);
        show(4'b0100, pat[3], 4);
        show(4'b0010, pat[4], 1);
        show(4'b0001, pat[5], 4);
        show(4'b0000, 7'h00, 2);
        show(4'b0010, pat[4], 4);
        show(4'b0000, 7'h00, 2);
        check_state("t2");

        // blank mo pattern, then 12:34 twice
        frame_seg(pat[2], pat[3], pat[4], 7'h00, 4);
        check("t3_unchanged", data_out, 12'h5ED);
        frame(1, 2, 3, 4, 4);
        frame(1, 2, 3, 4, 4);
        check("t3_value", data_out, 12'h322);

        // out-of-range hours and minute tens
        frame(2, 4, 0, 0, 3);
        frame(2, 4, 0, 0, 3);
        frame(1, 0, 6, 0, 3);
        frame(1, 0, 6, 0, 3);
        check("t4_unchanged", data_out, 12'h322);
        check_state("t4");

        // illegal select mid-frame, then 00:00 from a fresh reset
        do_reset();
        show(4'b1000, pat[1], 3);
        show(4'b0100, pat[1], 3);
        show(4'b0011, pat[1], 3);
        show(4'b0000, 7'h00, 2);
        frame(0, 0, 0, 0, 3);
        frame(0, 0, 0, 0, 3);
        check("t5_value", data_out, 0);
        check("t5_locked", locked, 1);

        // reset between the two frames of a pair
        do_reset();
        frame(1, 2, 3, 4, 3);
        do_reset();
        frame(1, 2, 3, 4, 3);
        check("t6_not_locked", locked, 0);
        frame(1, 2, 3, 4, 3);
        check("t6_value", data_out, 12'h322);
        check_state("t6");

        // randomized scans
        for (int it = 0; it < 60; it++) begin
            ht = $urandom_range(0, 2);
            ho = $urandom_range(0, 9);
            mt = $urandom_range(0, 6);
            mo = $urandom_range(0, 9);
            rep = $urandom_range(1, 3);
            for (int r = 0; r < rep; r++) begin
                s[3] = pat[ht]; s[2] = pat[ho]; s[1] = pat[mt]; s[0] = pat[mo];
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 19) == 0) s[k] = 7'($urandom_range(0, 127));
                for (int k = 3; k >= 0; k--) begin
                    len = $urandom_range(1, 4);
                    show(4'(1 << k), s[k], len);
                    if ($urandom_range(0, 29) == 0)
                        show(bad_sel[$urandom_range(0, 7)], 7'h00, $urandom_range(1, 3));
                end
                show(4'b0000, 7'h00, $urandom_range(1, 3));
            end
            if (it % 15 == 14) check_state("rand");
        end

        show(4'b0000, 7'h00, 4);
        check_state("final");
        check("q_dv_empty", q_dv.size(), 0);
        check("q_seg_empty", q_seg.size(), 0);
        check("q_sel_empty", q_sel.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
